// File: rtl/vga_frame_driver.sv
// vga_frame_driver: pixel-clock divider, raster counters, sync decode
// and blank-gated registered RGB for the paddle/ball display path.
//
// Ports:
//   clk, reset         system clock, async active-high reset
//   pixel_tick         one-clk pulse every CLK_DIV clocks
//   x, y               current raster position
//   video_on           x/y inside the visible area
//   endofframe         registered level, high while y >= V_DISPLAY
//   frame_tick         one-clk pulse when endofframe rises
//   ball_on/ball_rgb   ball coverage and colour (highest priority)
//   paddle_on/_rgb     paddle coverage and colour
//   bg_rgb             background colour
//   hsync, vsync       active-low syncs, aligned with RGB
//   vga_red/green/blue registered colour, {r[2:0], g[2:0], b[1:0]}
module vga_frame_driver #(
    parameter int CLK_DIV   = 4,
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic       pixel_tick,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       video_on,
    output logic       endofframe,
    output logic       frame_tick,
    input  logic       ball_on,
    input  logic [7:0] ball_rgb,
    input  logic       paddle_on,
    input  logic [7:0] paddle_rgb,
    input  logic [7:0] bg_rgb,
    output logic       hsync,
    output logic       vsync,
    output logic [2:0] vga_red,
    output logic [2:0] vga_green,
    output logic [1:0] vga_blue
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DW      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_ONE = DW'(1);
    localparam logic [9:0] X_MAX    = 10'(H_TOTAL - 1);
    localparam logic [9:0] Y_MAX    = 10'(V_TOTAL - 1);
    localparam logic [9:0] X_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] Y_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [DW-1:0] div_q, div_d;
    logic [9:0]    x_q, x_d;
    logic [9:0]    y_q, y_d;
    logic          eof_q, eof_d;
    logic          ft_q, ft_d;
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;
    logic [7:0]    rgb_q, rgb_d;
    logic          tick;
    logic          vis;
    logic [7:0]    pix;

    assign tick = (div_q == DIV_MAX);
    assign vis  = (x_q < X_VIS) && (y_q < Y_VIS);

    always_comb begin
        pix = bg_rgb;
        if (ball_on) begin
            pix = ball_rgb;
        end else if (paddle_on) begin
            pix = paddle_rgb;
        end
    end

    // Sync and colour are sampled from the pre-update x/y, so both
    // leave the registers exactly one pixel behind the counters.
    always_comb begin
        div_d = tick ? '0 : div_q + DIV_ONE;
        x_d   = x_q;
        y_d   = y_q;
        eof_d = eof_q;
        hs_d  = hs_q;
        vs_d  = vs_q;
        rgb_d = rgb_q;
        if (tick) begin
            if (x_q == X_MAX) begin
                x_d = '0;
                y_d = (y_q == Y_MAX) ? '0 : y_q + 10'd1;
            end else begin
                x_d = x_q + 10'd1;
            end
            eof_d = (y_d >= Y_VIS);
            hs_d  = !((x_q >= HS_FIRST) && (x_q <= HS_LAST));
            vs_d  = !((y_q >= VS_FIRST) && (y_q <= VS_LAST));
            rgb_d = vis ? pix : 8'h00;
        end
        ft_d = eof_d && !eof_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q <= '0;
            x_q   <= '0;
            y_q   <= '0;
            eof_q <= 1'b0;
            ft_q  <= 1'b0;
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
            rgb_q <= 8'h00;
        end else begin
            div_q <= div_d;
            x_q   <= x_d;
            y_q   <= y_d;
            eof_q <= eof_d;
            ft_q  <= ft_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            rgb_q <= rgb_d;
        end
    end

    assign pixel_tick = tick;
    assign x          = x_q;
    assign y          = y_q;
    assign video_on   = vis;
    assign endofframe = eof_q;
    assign frame_tick = ft_q;
    assign hsync      = hs_q;
    assign vsync      = vs_q;
    assign vga_red    = rgb_q[7:5];
    assign vga_green  = rgb_q[4:2];
    assign vga_blue   = rgb_q[1:0];

endmodule

// File: tb/tb_vga_frame_driver.sv
// tb_vga_frame_driver: directed bench for vga_frame_driver with full
// horizontal timing and a shortened vertical raster (8 lines).
module tb_vga_frame_driver;

    localparam int CDIV = 4;
    localparam int HD   = 640;
    localparam int HF   = 16;
    localparam int HS   = 96;
    localparam int HB   = 48;
    localparam int VD   = 4;
    localparam int VF   = 1;
    localparam int VS   = 2;
    localparam int VB   = 1;
    localparam int HT   = HD + HF + HS + HB;
    localparam int VT   = VD + VF + VS + VB;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pixel_tick;
    logic [9:0] x;
    logic [9:0] y;
    logic       video_on;
    logic       endofframe;
    logic       frame_tick;
    logic       ball_on = 1'b0;
    logic [7:0] ball_rgb = 8'h00;
    logic       paddle_on = 1'b0;
    logic [7:0] paddle_rgb = 8'h00;
    logic [7:0] bg_rgb = 8'h00;
    logic       hsync;
    logic       vsync;
    logic [2:0] vga_red;
    logic [2:0] vga_green;
    logic [1:0] vga_blue;
    logic [7:0] rgb;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int ft_seen = 0;
    int mx = 0;
    int my = 0;

    vga_frame_driver #(
        .CLK_DIV(CDIV), .H_DISPLAY(HD), .H_FRONT(HF),
        .H_SYNC(HS), .H_BACK(HB), .V_DISPLAY(VD),
        .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .clk(clk), .reset(reset), .pixel_tick(pixel_tick),
        .x(x), .y(y), .video_on(video_on),
        .endofframe(endofframe), .frame_tick(frame_tick),
        .ball_on(ball_on), .ball_rgb(ball_rgb),
        .paddle_on(paddle_on), .paddle_rgb(paddle_rgb),
        .bg_rgb(bg_rgb), .hsync(hsync), .vsync(vsync),
        .vga_red(vga_red), .vga_green(vga_green),
        .vga_blue(vga_blue)
    );

    assign rgb = {vga_red, vga_green, vga_blue};

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;
    always @(posedge frame_tick) ft_seen++;

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    task automatic apply_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        mx = 0;
        my = 0;
    endtask

    // Advance to the falling edge after the next pixel_tick edge and
    // step the reference raster position.
    task automatic next_pix();
        int n = 0;
        while (pixel_tick !== 1'b1 && n < 16) begin
            @(negedge clk);
            n++;
        end
        if (pixel_tick !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL pix_timeout got=%b want=1", pixel_tick);
        end
        @(negedge clk);
        if (mx == HT - 1) begin
            mx = 0;
            my = (my == VT - 1) ? 0 : my + 1;
        end else begin
            mx++;
        end
    endtask

    task automatic test_reset();
        logic early;
        ball_on = 0; paddle_on = 0;
        ball_rgb = 0; paddle_rgb = 0; bg_rgb = 0;
        reset = 1'b1;
        @(negedge clk);
        total++;
        if ({x, y} !== 20'd0) begin
            bad++;
            $display("FAIL rst_xy got=%0d,%0d want=0,0", x, y);
        end
        total++;
        if ({pixel_tick, endofframe, frame_tick} !== 3'b000) begin
            bad++;
            $display("FAIL rst_pulses got=%b%b%b want=000",
                     pixel_tick, endofframe, frame_tick);
        end
        total++;
        if ({hsync, vsync, video_on} !== 3'b111) begin
            bad++;
            $display("FAIL rst_sync got=%b%b%b want=111",
                     hsync, vsync, video_on);
        end
        total++;
        if (rgb !== 8'h00) begin
            bad++;
            $display("FAIL rst_rgb got=%h want=00", rgb);
        end
        reset = 1'b0;
        early = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (pixel_tick !== 1'b0) early = 1'b1;
        end
        total++;
        if (early !== 1'b0) begin
            bad++;
            $display("FAIL tick_early got=1 want=0");
        end
        @(negedge clk);
        total++;
        if ({pixel_tick, x} !== {1'b1, 10'd0}) begin
            bad++;
            $display("FAIL tick_cyc4 got=%b,x=%0d want=1,x=0",
                     pixel_tick, x);
        end
        @(negedge clk);
        total++;
        if ({pixel_tick, x, y} !== {1'b0, 10'd1, 10'd0}) begin
            bad++;
            $display("FAIL first_step got=%b,%0d,%0d want=0,1,0",
                     pixel_tick, x, y);
        end
        total++;
        if ({hsync, vsync, rgb} !== {2'b11, 8'h00}) begin
            bad++;
            $display("FAIL first_out got=%b%b,%h want=11,00",
                     hsync, vsync, rgb);
        end
    endtask

    task automatic test_line();
        int first_low = -1;
        int lows = 0;
        int xy_err = 0;
        apply_reset();
        for (int k = 1; k <= HT; k++) begin
            next_pix();
            if (x !== 10'(mx) || y !== 10'(my)) xy_err++;
            if (hsync === 1'b0) begin
                lows++;
                if (first_low < 0) first_low = k;
            end
        end
        total++;
        if (xy_err !== 0) begin
            bad++;
            $display("FAIL line_xy got=%0d errs want=0", xy_err);
        end
        total++;
        if (lows !== HS) begin
            bad++;
            $display("FAIL hs_width got=%0d want=%0d", lows, HS);
        end
        total++;
        if (first_low !== HD + HF + 1) begin
            bad++;
            $display("FAIL hs_start got=%0d want=%0d",
                     first_low, HD + HF + 1);
        end
        total++;
        if ({x, y} !== {10'd0, 10'd1}) begin
            bad++;
            $display("FAIL line_wrap got=%0d,%0d want=0,1", x, y);
        end
    endtask

    task automatic test_frame();
        int c0, f0, px, py;
        int xy_err = 0, sy_err = 0, rgb_err = 0, eof_err = 0;
        int vs_low = 0, eof_hi = 0;
        logic ehs, evs, eeof, eft;
        logic [7:0] ergb;
        apply_reset();
        ball_on = 1; paddle_on = 1;
        ball_rgb = 8'h1C; paddle_rgb = 8'h03; bg_rgb = 8'hE0;
        c0 = cyc;
        f0 = ft_seen;
        for (int n = 0; n < HT * VT; n++) begin
            px = mx;
            py = my;
            next_pix();
            ehs  = !(px >= HD + HF && px < HD + HF + HS);
            evs  = !(py >= VD + VF && py < VD + VF + VS);
            ergb = (px < HD && py < VD) ? 8'h1C : 8'h00;
            eeof = (my >= VD);
            eft  = (my == VD && mx == 0);
            if (x !== 10'(mx) || y !== 10'(my)) xy_err++;
            if (hsync !== ehs || vsync !== evs) sy_err++;
            if (rgb !== ergb) begin
                if (rgb_err == 0)
                    $display("rgb at %0d,%0d got=%h want=%h",
                             px, py, rgb, ergb);
                rgb_err++;
            end
            if (endofframe !== eeof || frame_tick !== eft) eof_err++;
            if (vsync === 1'b0) vs_low++;
            if (endofframe === 1'b1) eof_hi++;
        end
        ball_on = 0; paddle_on = 0;
        total++;
        if (xy_err !== 0) begin
            bad++;
            $display("FAIL frame_xy got=%0d errs want=0", xy_err);
        end
        total++;
        if (sy_err !== 0) begin
            bad++;
            $display("FAIL frame_sync got=%0d errs want=0", sy_err);
        end
        total++;
        if (rgb_err !== 0) begin
            bad++;
            $display("FAIL colour_prio got=%0d errs want=0", rgb_err);
        end
        total++;
        if (eof_err !== 0) begin
            bad++;
            $display("FAIL eof_timing got=%0d errs want=0", eof_err);
        end
        total++;
        if (vs_low !== VS * HT) begin
            bad++;
            $display("FAIL vs_width got=%0d want=%0d", vs_low, VS * HT);
        end
        total++;
        if (eof_hi !== (VT - VD) * HT) begin
            bad++;
            $display("FAIL eof_width got=%0d want=%0d",
                     eof_hi, (VT - VD) * HT);
        end
        total++;
        if (ft_seen - f0 !== 1) begin
            bad++;
            $display("FAIL ft_count got=%0d want=1", ft_seen - f0);
        end
        total++;
        if (cyc - c0 !== HT * VT * CDIV) begin
            bad++;
            $display("FAIL frame_len got=%0d want=%0d",
                     cyc - c0, HT * VT * CDIV);
        end
        total++;
        if ({x, y} !== 20'd0) begin
            bad++;
            $display("FAIL frame_wrap got=%0d,%0d want=0,0", x, y);
        end
    endtask

    task automatic test_paddle();
        apply_reset();
        ball_on = 0; paddle_on = 0;
        ball_rgb = 8'h1C; paddle_rgb = 8'h03; bg_rgb = 8'hE0;
        while (!(mx == 600 && my == 2)) next_pix();
        total++;
        if (rgb !== 8'hE0) begin
            bad++;
            $display("FAIL pad_before got=%h want=e0", rgb);
        end
        paddle_on = 1;
        next_pix();
        paddle_on = 0;
        total++;
        if ({x, rgb} !== {10'd601, 8'h03}) begin
            bad++;
            $display("FAIL pad_hit got=x%0d,%h want=x601,03", x, rgb);
        end
        next_pix();
        total++;
        if (rgb !== 8'hE0) begin
            bad++;
            $display("FAIL pad_after got=%h want=e0", rgb);
        end
    endtask

    task automatic test_reset_midline();
        int f0;
        apply_reset();
        ball_on = 0; paddle_on = 0; bg_rgb = 8'hFF;
        while (!(mx == 300 && my == 2)) next_pix();
        @(negedge clk);
        total++;
        if ({x, y, rgb} !== {10'd300, 10'd2, 8'hFF}) begin
            bad++;
            $display("FAIL mid_pre got=%0d,%0d,%h want=300,2,ff",
                     x, y, rgb);
        end
        reset = 1'b1;
        #1;
        total++;
        if ({x, y, rgb} !== {20'd0, 8'h00}) begin
            bad++;
            $display("FAIL mid_rst got=%0d,%0d,%h want=0,0,00",
                     x, y, rgb);
        end
        total++;
        if ({pixel_tick, endofframe, frame_tick, hsync, vsync,
             video_on} !== 6'b000111) begin
            bad++;
            $display("FAIL mid_rst_ctl got=%b%b%b%b%b%b want=000111",
                     pixel_tick, endofframe, frame_tick,
                     hsync, vsync, video_on);
        end
        @(negedge clk);
        reset = 1'b0;
        f0 = ft_seen;
        repeat (CDIV) @(negedge clk);
        total++;
        if ({x, y} !== {10'd1, 10'd0}) begin
            bad++;
            $display("FAIL mid_restart got=%0d,%0d want=1,0", x, y);
        end
        total++;
        if (ft_seen - f0 !== 0) begin
            bad++;
            $display("FAIL mid_ft got=%0d want=0", ft_seen - f0);
        end
        bg_rgb = 8'h00;
    endtask

    initial begin
        test_reset();
        test_line();
        test_frame();
        test_paddle();
        test_reset_midline();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_frame_driver.md
# vga_frame_driver

Display-side end of the pixel interface used by the paddle and ball blocks. It divides the system clock into a pixel tick and runs 640x480 horizontal and vertical counters. It publishes the current `x`/`y` coordinate and the `endofframe` level that clocks the movement blocks. It takes back the `*_on` and colour signals from the graphics blocks and drives registered, blank-gated VGA RGB and active-low sync outputs.

## Interface
- `CLK_DIV`, 4, system clocks per pixel (100 MHz -> 25 MHz); must be >= 2
- `H_DISPLAY`, 640, visible pixels per line
- `H_FRONT`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width (pixels)
- `H_BACK`, 48, horizontal back porch (pixels)
- `V_DISPLAY`, 480, visible lines
- `V_FRONT`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BACK`, 33, vertical back porch (lines)
- `clk`  in  1  system clock
- `reset`  in  1  reset, asynchronous, active-high
- `pixel_tick`  out  1  one-`clk` pulse every `CLK_DIV` clocks
- `x`  out  10  horizontal count, 0..H_TOTAL-1 (H_TOTAL = 800)
- `y`  out  10  vertical count, 0..V_TOTAL-1 (V_TOTAL = 525)
- `video_on`  out  1  high while x < H_DISPLAY and y < V_DISPLAY
- `endofframe`  out  1  registered level, high while y >= V_DISPLAY
- `frame_tick`  out  1  one-`clk` pulse on the rising edge of `endofframe`
- `ball_on`  in  1  ball covers current x,y
- `ball_rgb`  in  8  {red[2:0], green[2:0], blue[1:0]}
- `paddle_on`  in  1  a paddle covers current x,y
- `paddle_rgb`  in  8  same packing as `ball_rgb`
- `bg_rgb`  in  8  background colour
- `hsync`  out  1  active-low horizontal sync
- `vsync`  out  1  active-low vertical sync
- `vga_red`  out  3  red
- `vga_green`  out  3  green
- `vga_blue`  out  2  blue

## Operation
- **Divider.**
  - Counter runs 0..CLK_DIV-1.
  - `pixel_tick` is high in the `clk` cycle where the divider equals CLK_DIV-1.
- **Counters.** Update only on `pixel_tick`.
  - `x` increments. At H_TOTAL-1 it wraps to 0 and `y` increments.
  - At `x` = H_TOTAL-1 and `y` = V_TOTAL-1, both wrap to 0.
- **Sync.** Decoded from the counter values before delay.
  - `hsync` is low for x in [656, 751].
  - `vsync` is low for y in [490, 491].
- **Pixel mux.** Evaluated combinationally on the current `x`/`y`; inputs are combinational functions of `x`/`y`.
  - Priority: `ball_on` -> `ball_rgb`, else `paddle_on` -> `paddle_rgb`, else `bg_rgb`.
  - Forced to 0 when `video_on` is low.
- **Output registers.**
  - RGB, `hsync` and `vsync` are registered on `pixel_tick`, so they lag `x`/`y` by exactly one pixel period.
  - This keeps colour and sync mutually aligned.
- **`endofframe`.**
  - Set on the `pixel_tick` that moves `y` to V_DISPLAY (x wraps from 799 to 0, y goes 479 -> 480).
  - Cleared on the tick that wraps `y` to 0.
  - High for 45 lines.
  - Movement blocks sample the final displayed frame's positions on its rising edge.
- **`frame_tick`.** Asserted for exactly one `clk` in the same cycle that `endofframe` rises.
- **Reset values** (async, immediate, including mid-frame; counting restarts from 0,0 on release):
  - divider, `x`, `y` = 0
  - `pixel_tick`, `endofframe`, `frame_tick` = 0
  - `hsync` = `vsync` = 1
  - RGB = 0
  - `video_on` = 1 (combinational from x = y = 0)

## Timing
- First `pixel_tick` occurs CLK_DIV `clk` cycles after reset deasserts.
- Line period: 800 ticks = 3200 `clk`. Frame period: 525 lines = 1,680,000 `clk`.
- `x`/`y` change one `clk` after a `pixel_tick`-high cycle.
- Registered outputs (RGB, sync, `endofframe`) update on the same edge as `x`/`y`.
- `frame_tick` is registered with `endofframe`: one pulse per frame, never at reset release.
- When `ball_on` and `paddle_on` are both high, the ball wins.
- Any `*_on` input asserted outside the visible area is ignored; output is 0.
- `x`, `y` never exceed 799, 524; there are no off-by-one extra ticks at either wrap.

## Test plan
- **Reset then run 4 clk** -> `pixel_tick` pulses in cycle 4; `x` goes 0 -> 1; `hsync`/`vsync` = 1; RGB = 0.
- **Run one line** -> `hsync` low for exactly 96 ticks, starting 657 ticks after line start (one-pixel delay); `x` wraps 799 -> 0 and `y` goes 0 -> 1.
- **Run one full frame** ->
  - `vsync` low exactly 2 lines;
  - `endofframe` rises at the `y` 479 -> 480 transition and stays high 45 lines;
  - exactly one `frame_tick`;
  - frame length 1,680,000 `clk`.
- **Hold `ball_on` = `paddle_on` = 1, `ball_rgb` = 8'h1C, `paddle_rgb` = 8'h03, `bg_rgb` = 8'hE0** -> visible pixels show green = 3'b111, red = blue = 0; during blanking RGB = 0.
- **`paddle_on` only at x = 600, y = 100** -> `vga_blue` = 2'b11 appears one pixel tick after `x` = 600; `bg_rgb` is shown on neighbouring pixels.
- **Assert `reset` mid-line at x = 300, y = 200** -> all outputs take their reset values in the same cycle; after release, counting restarts at 0,0 with no spurious `frame_tick`.
